// File: rtl/overlay_out_collector.sv
// rtl/overlay_out_collector.sv - capture FIFO with frame tagging and overflow flag for the overlay result stream
module overlay_out_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_NUM     = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_v,
  input  logic [2*DATA_WIDTH-1:0]   din,
  input  logic                      flush,
  output logic                      m_valid,
  output logic [2*DATA_WIDTH-1:0]   m_data,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(PE_NUM);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PE_NUM - 1);

  // Each entry carries the word plus its end-of-frame tag in the top bit
  logic [WW:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [BW-1:0]  beat;
  logic [WW:0]    head;
  logic           full;
  logic           pop;
  logic           push;
  logic           drop;

  // Handshake decode; a pop on a full FIFO frees the slot for the incoming word
  always_comb begin
    full = (count == FULL_CNT);
    pop  = m_valid & m_ready;
    push = din_v & (~full | pop) & ~flush;
    drop = din_v & full & ~pop & ~flush;
  end

  // First-word-fall-through output, gated so stale memory never shows
  always_comb begin
    head    = mem[rd_ptr];
    m_valid = (count != '0);
    m_data  = m_valid ? head[WW-1:0] : '0;
    m_last  = m_valid ? head[WW] : 1'b0;
  end

  // Storage array; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {(beat == LAST_BEAT), din};
    end
  end

  // Pointers, occupancy and frame position; beat advances even on dropped words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (din_v) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
